fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares the single write port of the 16x8 sync FIFO among NREQ producers.
//   - Arbitration: round-robin, with a bounded burst per grant.
//   - Drives fifo wr/datain and back-pressures producers with per-requester ready.
//   - Keeps a shadow occupancy count from observed wr/rd beats; exports level and almost-full.
//   - Sits between the producer blocks and the FIFO; the FIFO read side stays with the consumer.
// PARAMETERS
//   NREQ       4   number of requesters (2..8)
//   DW         8   data width; matches the FIFO datain/dataout
//   DEPTH      16  FIFO depth; level is $clog2(DEPTH)+1 bits wide
//   MAX_BURST  4   max accepted beats per grant (1..15)
//   AFULL_TH   12  afull asserts when level >= AFULL_TH
// PORTS
//   clk          in   1          rising-edge clock
//   rst          in   1          asynchronous reset, active-high
//   req_valid    in   NREQ       producer i has a beat on req_data[i*DW +: DW]
//   req_data     in   NREQ*DW    packed producer data
//   req_ready    out  NREQ       beat i accepted this cycle when valid&ready
//   fifo_wr      out  1          FIFO write strobe
//   fifo_datain  out  DW         FIFO write data
//   fifo_full    in   1          FIFO full flag
//   fifo_rd      in   1          consumer read strobe (observed only)
//   fifo_empty   in   1          FIFO empty flag
//   grant_id     out  3          index of current grantee; valid while busy
//   busy         out  1          state==GRANT
//   level        out  $clog2(DEPTH)+1  shadow occupancy
//   afull        out  1          level >= AFULL_TH
// BEHAVIOUR
//   Reset values: state=IDLE, last=NREQ-1, grant_id=0, beat_cnt=0, level=0.
//     All outputs are 0 during reset: req_ready, fifo_wr, busy, afull.
//   FSM IDLE:
//     - If any req_valid: pick the first valid index scanning last+1, last+2, ... (mod NREQ).
//     - Register it into grant_id and set last=grant_id; beat_cnt=0; go to GRANT.
//     - Arbitration latency: 1 cycle; no data is accepted in IDLE.
//   FSM GRANT (g=grant_id):
//     - req_ready[g] = ~fifo_full; all other ready bits are 0.
//     - fifo_wr = req_valid[g] & ~fifo_full, combinational; fifo_datain = req_data[g].
//     - Each accepted beat increments beat_cnt.
//     - Exit to IDLE when an accepted beat makes beat_cnt==MAX_BURST,
//       or when req_valid[g]==0 in GRANT.
//     - fifo_full stalls the burst without releasing the grant.
//   Fairness: the released grantee gets lowest priority at the next arbitration.
//     One IDLE cycle always separates grants.
//   Level accounting: wr_acc = fifo_wr; rd_acc = fifo_rd & ~fifo_empty.
//     - wr_acc only: +1. rd_acc only: -1. Both or neither: unchanged.
//     - Saturates at 0 and at DEPTH; never wraps.
//   afull is combinational from level.
//   The arbiter never asserts fifo_wr while fifo_full=1, so the FIFO's drop-on-full is never hit.
//   rst mid-burst: immediately returns to IDLE, drops ready/wr, clears level.
//     Producers must re-present the beat that was not accepted.
// TESTING
//   1 Reset, req_valid=4'b0001, data 0x10..0x13, MAX_BURST=4
//     -> grant_id=0 after 1 cycle; 4 writes on consecutive cycles; IDLE; level=4.
//   2 req_valid=4'b1111 held
//     -> grant order 0,1,2,3,0; exactly 4 beats each; one IDLE gap between grants.
//   3 Fill: fifo_full=1 mid-burst at beat 2
//     -> fifo_wr=0 and req_ready=0 while full; grant held; beats 3,4 resume when full drops.
//   4 Simultaneous fifo_wr and fifo_rd with fifo_empty=0 at level=5
//     -> level stays 5; rd with fifo_empty=1 at level=0 -> stays 0.
//   5 level climbs 11->12 -> afull=1 same cycle level updates; drops to 11 -> afull=0.
//   6 rst=1 during GRANT beat 2
//     -> busy, req_ready, fifo_wr =0 asynchronously; level=0; after release next grant starts from index 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the FIFO write port with bounded bursts,
// per-requester back-pressure and a shadow occupancy count with almost-full.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4,
  parameter int AFULL_TH  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      fifo_wr,
  output logic [DW-1:0]             fifo_datain,
  input  logic                      fifo_full,
  input  logic                      fifo_rd,
  input  logic                      fifo_empty,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      afull
);

  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_id_q, grant_id_d;
  logic [2:0]    last_q, last_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;
  logic [LW-1:0] level_q, level_d;

  logic          g_valid;
  logic [DW-1:0] g_data;
  logic          found;
  logic [2:0]    pick;
  logic          wr_acc, rd_acc;

  // Select the current grantee's valid and data lanes.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*DW +: DW];
      end
    end
  end

  // Ready and write strobe exist only in GRANT; full stalls without dropping the grant.
  always_comb begin
    req_ready = '0;
    fifo_wr   = 1'b0;
    if (state_q == GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_id_q == 3'(i)) req_ready[i] = ~fifo_full;
      end
      fifo_wr = g_valid & ~fifo_full;
    end
  end

  assign fifo_datain = g_data;

  // Round-robin pick: scan last+1, last+2, ... so the previous grantee comes last.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_valid[j] && (((int'(last_q) + k) % NREQ) == j)) begin
          found = 1'b1;
          pick  = 3'(j);
        end
      end
    end
  end

  // FSM next state, burst counting and shadow level accounting.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          grant_id_d = pick;
          last_d     = pick;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!g_valid) begin
          state_d = IDLE;
        end else if (fifo_wr) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (beat_cnt_q + 4'd1 == 4'(MAX_BURST)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_acc  = fifo_wr;
    rd_acc  = fifo_rd & ~fifo_empty;
    level_d = level_q;
    if (wr_acc && !rd_acc && (level_q != LW'(DEPTH)))
      level_d = level_q + LW'(1);
    else if (rd_acc && !wr_acc && (level_q != '0))
      level_d = level_q - LW'(1);
  end

  // State registers; reset parks the pointer so index 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_q     <= 3'(NREQ - 1);
      beat_cnt_q <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      level_q    <= level_d;
    end
  end

  assign busy     = (state_q == GRANT);
  assign grant_id = grant_id_q;
  assign level    = level_q;
  assign afull    = (level_q >= LW'(AFULL_TH));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes are queued at stimulus
// time and popped by an independent monitor whenever fifo_wr is presented.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int LW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_wr;
  logic [DW-1:0]        fifo_datain;
  logic                 fifo_full, fifo_rd, fifo_empty;
  logic [2:0]           grant_id;
  logic                 busy;
  logic [LW-1:0]        level;
  logic                 afull;

  fifo_wr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr(fifo_wr), .fifo_datain(fifo_datain),
    .fifo_full(fifo_full), .fifo_rd(fifo_rd), .fifo_empty(fifo_empty),
    .grant_id(grant_id), .busy(busy), .level(level), .afull(afull)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_count = 0;
  int prev_gid = -1;
  int idle_seen = 1;
  logic [10:0] exp_q[$];
  int wr_stamp[$];
  logic [7:0] pq[NREQ][$];
  logic [NREQ-1:0] take;
  logic [10:0] e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (pq[i].size() > 0);
      req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
    end
  endtask

  task automatic load(input int i, input logic [7:0] d, input bit push_exp);
    pq[i].push_back(d);
    if (push_exp) exp_q.push_back({3'(i), d});
    drive_reqs();
  endtask

  function automatic bit prod_pending();
    bit p = 0;
    for (int i = 0; i < NREQ; i++) if (pq[i].size() > 0) p = 1;
    return p;
  endfunction

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!busy) idle_seen = 1;
    if (fifo_full && busy) begin
      check("no_wr_on_full", fifo_wr, 0);
      check("no_ready_on_full", req_ready, 0);
    end
    if (fifo_wr) begin
      wr_count++;
      wr_stamp.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wr: got gid %0d data %0h expected no write", grant_id, fifo_datain);
      end else begin
        e = exp_q.pop_front();
        check("wr_gid", grant_id, e[10:8]);
        check("wr_data", fifo_datain, e[7:0]);
      end
      if (prev_gid >= 0 && prev_gid != int'(grant_id)) check("idle_gap", idle_seen, 1);
      prev_gid = grant_id;
      idle_seen = 0;
    end
  end

  // producers: pop the head when the beat was accepted at the edge
  initial forever begin
    @(negedge clk);
    take = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (take[i] && !rst) void'(pq[i].pop_front());
    drive_reqs();
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, 0);
    check("rst_level", level, 0);
    check("rst_afull", afull, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr", fifo_wr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || busy || prod_pending()) && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, (n < maxc) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s0, n;
    rst = 1'b1; fifo_full = 1'b0; fifo_rd = 1'b0; fifo_empty = 1'b1;
    req_valid = '0; req_data = '0;
    repeat (2) @(posedge clk);

    // 1: single requester, one full burst
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) load(0, 8'(8'h10 + k), 1);
    s0 = wr_stamp.size();
    @(negedge clk); #1;
    check("t1_arb_cycle_idle", busy, 0);
    @(negedge clk); #1;
    check("t1_busy", busy, 1);
    check("t1_gid", grant_id, 0);
    wait_drain("t1_drain", 50);
    check("t1_count", wr_stamp.size() - s0, 4);
    if (wr_stamp.size() - s0 == 4) check("t1_consecutive", wr_stamp[s0+3] - wr_stamp[s0], 3);
    check("t1_level", level, 4);
    check("t1_idle", busy, 0);

    // 2: all requesters busy, rotation and level saturation
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 8; k++) load(i, 8'(i*16 + k), 0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        for (int b = 0; b < 4; b++) exp_q.push_back({3'(i), 8'(i*16 + r*4 + b)});
    wait_drain("t2_drain", 300);
    check("t2_level_sat", level, 16);
    check("t2_afull", afull, 1);

    // 3: full stalls mid-burst, grant held
    do_reset();
    @(posedge clk); #1;
    base = wr_count;
    for (int k = 0; k < 4; k++) load(1, 8'(8'hA0 + k), 1);
    n = 0;
    while (wr_count < base + 2 && n < 20) begin @(negedge clk); #1; n++; end
    check("t3_reach_beat2", wr_count - base, 2);
    @(posedge clk); #2;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("t3_hold_busy", busy, 1);
      check("t3_hold_gid", grant_id, 1);
      check("t3_stall_wr", fifo_wr, 0);
      check("t3_stall_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    wait_drain("t3_drain", 50);
    check("t3_beats", wr_count - base, 4);
    check("t3_level", level, 4);

    // 4: simultaneous wr/rd, read-only decrement, empty and zero floor
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) load(2, 8'(8'h20 + k), 1);
    wait_drain("t4_drain_a", 50);
    check("t4_level5", level, 5);
    @(posedge clk); #1;
    load(2, 8'h25, 1);
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); #1; n++; end
    check("t4_busy", busy, 1);
    check("t4_wr", fifo_wr, 1);
    fifo_rd = 1'b1; fifo_empty = 1'b0;
    @(posedge clk); #1;
    fifo_rd = 1'b0;
    @(negedge clk); #1;
    check("t4_wr_rd_level", level, 5);
    @(posedge clk); #1;
    fifo_rd = 1'b1;
    @(posedge clk); #1;
    fifo_rd = 1'b0;
    @(negedge clk); #1;
    check("t4_rd_level", level, 4);
    wait_drain("t4_drain_b", 50);
    fifo_empty = 1'b1;
    do_reset();
    @(posedge clk); #1;
    fifo_rd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fifo_rd = 1'b0;
    @(negedge clk); #1;
    check("t4_rd_empty_level", level, 0);
    @(posedge clk); #1;
    fifo_rd = 1'b1; fifo_empty = 1'b0;
    @(posedge clk); #1;
    fifo_rd = 1'b0; fifo_empty = 1'b1;
    @(negedge clk); #1;
    check("t4_floor_level", level, 0);

    // 5: afull threshold crossing both ways
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 11; k++) load(3, 8'(8'h30 + k), 1);
    wait_drain("t5_drain_a", 100);
    check("t5_level11", level, 11);
    check("t5_afull_off", afull, 0);
    @(posedge clk); #1;
    load(3, 8'h3B, 1);
    n = 0;
    while (level != 12 && n < 10) begin @(negedge clk); #1; n++; end
    check("t5_level12", level, 12);
    check("t5_afull_on", afull, 1);
    wait_drain("t5_drain_b", 50);
    @(posedge clk); #1;
    fifo_rd = 1'b1; fifo_empty = 1'b0;
    @(posedge clk); #1;
    fifo_rd = 1'b0; fifo_empty = 1'b1;
    @(negedge clk); #1;
    check("t5_level_back", level, 11);
    check("t5_afull_back", afull, 0);

    // 6: async reset mid-burst, beat re-presented, pointer back to index 0
    do_reset();
    @(posedge clk); #1;
    base = wr_count;
    for (int k = 0; k < 4; k++) load(0, 8'(8'h50 + k), 1);
    n = 0;
    while (wr_count < base + 1 && n < 20) begin @(negedge clk); #1; n++; end
    check("t6_reach_beat1", wr_count - base, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    load(1, 8'h61, 0);
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_ready", req_ready, 0);
    check("t6_async_wr", fifo_wr, 0);
    check("t6_async_level", level, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({3'd1, 8'h61});
    wait_drain("t6_drain", 50);
    check("t6_beats", wr_count - base, 5);
    check("t6_level", level, 4);

    check("sb_empty_at_end", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
